// File: rtl/result_deskew_writer_if.sv
// Handshake/bus bundle between the systolic array, the deskew writer and the results SRAM.
// No latency of its own; plain wires grouped for connection.
// No backpressure: the producer streams rows and the SRAM accepts every write.
interface result_deskew_writer_if #(
    parameter int MATRIX_SIZE    = 8,
    parameter int PARTIAL_SUM_BW = 20,
    parameter int ADDRESSSIZE    = 10
);
    logic                                  start;
    logic [ADDRESSSIZE-1:0]                base_addr;
    logic                                  in_valid;
    logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] psum_in;
    logic                                  wr_en;
    logic [ADDRESSSIZE-1:0]                wr_addr;
    logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] wr_data;
    logic                                  busy;
    logic                                  done;
    logic                                  err;

    modport master (
        output start, base_addr, in_valid, psum_in,
        input  wr_en, wr_addr, wr_data, busy, done, err
    );

    modport slave (
        input  start, base_addr, in_valid, psum_in,
        output wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/result_deskew_writer.sv
// Realigns skewed partial-sum rows into one word per row and writes a tile to the results SRAM.
// Latency: in_valid at cycle t -> registered wr_en at cycle t+MATRIX_SIZE; done one cycle after the last write.
// No backpressure: full-throughput input; in_valid outside COLLECT is dropped and flags sticky err.
// Optional feature: define RESULT_REVERSE_EN to place column 0 in the MSB slice of wr_data.
module result_deskew_writer #(
    parameter int MATRIX_SIZE    = 8,
    parameter int PARTIAL_SUM_BW = 20,
    parameter int ADDRESSSIZE    = 10,
    parameter int NUM_ROWS       = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    result_deskew_writer_if.slave  bus
);
    localparam int MS  = MATRIX_SIZE;
    localparam int PSB = PARTIAL_SUM_BW;
    localparam int AS  = ADDRESSSIZE;
    localparam int W   = PSB * MS;
    localparam int CW  = $clog2(NUM_ROWS + 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [AS-1:0]   base_q;
    logic [CW-1:0]   row_cnt_q;
    logic [CW-1:0]   wr_cnt_q;
    logic            err_q;
    logic [MS-2:0]   vld_q;
    logic            wr_en_q;
    logic [AS-1:0]   wr_addr_q;
    logic [W-1:0]    wr_data_q;
    logic [W-1:0]    aligned_row;
    logic            vld_out;
    logic            accept;
    logic            start_ok;

    assign accept   = bus.in_valid && (state_q == S_COLLECT);
    assign start_ok = bus.start && (state_q == S_IDLE);
    assign vld_out  = vld_q[MS-2];

    // Column c arrives c cycles late, so it waits MS-1-c more cycles; all columns line up at t+MS-1.
    for (genvar c = 0; c < MS; c++) begin : g_col
        localparam int D  = MS - 1 - c;
`ifdef RESULT_REVERSE_EN
        localparam int OC = MS - 1 - c;
`else
        localparam int OC = c;
`endif
        if (D == 0) begin : g_direct
            assign aligned_row[OC*PSB +: PSB] = bus.psum_in[c*PSB +: PSB];
        end else begin : g_delay
            logic [PSB-1:0] sh_q [D];
            // Data-only shift line; validity travels separately in vld_q.
            always_ff @(posedge clk) begin
                sh_q[0] <= bus.psum_in[c*PSB +: PSB];
                for (int i = 1; i < D; i++) begin
                    sh_q[i] <= sh_q[i-1];
                end
            end
            assign aligned_row[OC*PSB +: PSB] = sh_q[D-1];
        end
    end

    // Next-state logic for the tile sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.start) state_d = S_COLLECT;
            S_COLLECT: if (accept && row_cnt_q == CW'(NUM_ROWS - 1)) state_d = S_DRAIN;
            S_DRAIN:   if (wr_cnt_q == CW'(NUM_ROWS)) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State register plus the tile bookkeeping (base, counters, sticky error).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            row_cnt_q <= '0;
            wr_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                base_q    <= bus.base_addr;
                row_cnt_q <= '0;
                wr_cnt_q  <= '0;
                err_q     <= 1'b0;
            end else begin
                if (accept)  row_cnt_q <= row_cnt_q + CW'(1);
                if (vld_out) wr_cnt_q  <= wr_cnt_q + CW'(1);
                if (bus.in_valid && state_q != S_COLLECT) err_q <= 1'b1;
            end
        end
    end

    // Row-valid delay line and registered SRAM write port; reset flushes rows in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            vld_q   <= {vld_q[MS-3:0], accept};
            wr_en_q <= vld_out;
            if (vld_out) begin
                wr_addr_q <= base_q + AS'(wr_cnt_q);
                wr_data_q <= aligned_row;
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = (state_q == S_COLLECT) || (state_q == S_DRAIN);
    assign bus.done    = (state_q == S_DONE);
    assign bus.err     = err_q;
endmodule

// File: tb/tb_result_deskew_writer.sv
module tb_result_deskew_writer;
    localparam int MS  = 8;
    localparam int PSB = 20;
    localparam int AS  = 10;
    localparam int NR  = 8;
    localparam int W   = MS * PSB;
`ifdef RESULT_REVERSE_EN
    localparam int C0 = MS - 1;
    localparam int C3 = MS - 4;
`else
    localparam int C0 = 0;
    localparam int C3 = 3;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    result_deskew_writer_if #(.MATRIX_SIZE(MS), .PARTIAL_SUM_BW(PSB), .ADDRESSSIZE(AS)) bus ();

    result_deskew_writer #(.MATRIX_SIZE(MS), .PARTIAL_SUM_BW(PSB), .ADDRESSSIZE(AS), .NUM_ROWS(NR)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: rows keyed by in_valid cycle; expected writes keyed by the cycle wr_en must be seen.
    logic [W-1:0]  rows     [int];
    logic [AS-1:0] exp_addr [int];
    logic [W-1:0]  exp_data [int];
    logic [AS-1:0] addr_log [$];
    logic [W-1:0]  data_log [$];
    int            m_start_cyc = -100;
    int            m_busy_end  = -100;
    int            m_done_cyc  = -100;
    int            m_idle_from = 0;
    int            m_acc       = NR;
    int            m_wr_idx    = 0;
    bit            m_err       = 1'b0;
    logic [AS-1:0] m_base      = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [W-1:0] arrange(input logic [W-1:0] row);
        logic [W-1:0] r;
        for (int c = 0; c < MS; c++) begin
`ifdef RESULT_REVERSE_EN
            r[(MS-1-c)*PSB +: PSB] = row[c*PSB +: PSB];
`else
            r[c*PSB +: PSB] = row[c*PSB +: PSB];
`endif
        end
        return r;
    endfunction

    function automatic logic [W-1:0] mkrow(input int k, input int mode);
        logic [W-1:0] r;
        for (int c = 0; c < MS; c++) begin
            case (mode)
                0:       r[c*PSB +: PSB] = PSB'(k * 16 + c);
                2:       r[c*PSB +: PSB] = PSB'(-(k * MS + c + 1));
                default: r[c*PSB +: PSB] = PSB'($urandom);
            endcase
        end
        return r;
    endfunction

    // Drive one cycle of inputs (skewing every recorded row onto psum_in) and advance the model.
    task automatic drive(input bit rst, input bit st, input logic [AS-1:0] base, input bit iv,
                         input logic [W-1:0] row);
        logic [W-1:0] p;
        int t;
        rstn          = !rst;
        bus.start     = st;
        bus.base_addr = base;
        bus.in_valid  = iv;
        if (iv) rows[cyc] = row;
        for (int c = 0; c < MS; c++) begin
            if (rows.exists(cyc - c)) p[c*PSB +: PSB] = rows[cyc-c][c*PSB +: PSB];
            else                      p[c*PSB +: PSB] = PSB'($urandom);
        end
        bus.psum_in = p;
        if (rst) begin
            for (int k = cyc + 1; k <= cyc + MS; k++) begin
                exp_addr.delete(k);
                exp_data.delete(k);
            end
            if (m_done_cyc > cyc) m_done_cyc = -100;
            if (m_busy_end > cyc) m_busy_end = cyc + 1;
            m_idle_from = cyc + 1;
            m_acc       = NR;
            m_err       = 1'b0;
        end else begin
            if (iv) begin
                if (cyc > m_start_cyc && m_acc < NR && cyc < m_busy_end) begin
                    t = cyc + MS;
                    exp_addr[t] = m_base + AS'(m_wr_idx);
                    exp_data[t] = arrange(row);
                    addr_log.push_back(exp_addr[t]);
                    data_log.push_back(exp_data[t]);
                    m_wr_idx++;
                    m_acc++;
                    if (m_acc == NR) begin
                        m_done_cyc  = t + 1;
                        m_busy_end  = t + 1;
                        m_idle_from = t + 2;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
            if (st && cyc >= m_idle_from) begin
                m_start_cyc = cyc;
                m_busy_end  = 1 << 30;
                m_done_cyc  = -100;
                m_acc       = 0;
                m_wr_idx    = 0;
                m_base      = base;
                m_err       = 1'b0;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic run_tile(input logic [AS-1:0] base, input int gapmax, input int mode, input bit extra);
        int b;
        drive(1'b0, 1'b1, base, 1'b0, '0);
        for (int k = 0; k < NR; k++) begin
            idle($urandom_range(0, gapmax));
            drive(1'b0, 1'b0, '0, 1'b1, mkrow(k, mode));
        end
        if (extra) drive(1'b0, 1'b0, '0, 1'b1, mkrow(0, 1));
        b = 0;
        while (cyc <= m_done_cyc + 1 && b < 200) begin
            idle(1);
            b++;
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(posedge clk) begin
        cyc++;
        #1;
        chk("wr_en", W'(bus.wr_en), W'(exp_addr.exists(cyc)));
        if (exp_addr.exists(cyc)) begin
            chk("wr_addr", W'(bus.wr_addr), W'(exp_addr[cyc]));
            chk("wr_data", bus.wr_data, exp_data[cyc]);
        end
        chk("done", W'(bus.done), W'(cyc == m_done_cyc));
        chk("busy", W'(bus.busy), W'(cyc > m_start_cyc && cyc < m_busy_end));
        chk("err", W'(bus.err), W'(m_err));
    end

    initial begin
        int s;
        bus.start = 1'b0; bus.base_addr = '0; bus.in_valid = 1'b0; bus.psum_in = '0;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, '0, 1'b0, '0);

        // Back-to-back rows, k*16+c pattern.
        s = cyc;
        run_tile(10'h010, 0, 0, 1'b0);
        chk("m_first_wr", W'(exp_addr.exists(s + 1 + MS)), W'(1));
        chk("m_first_addr", W'(addr_log[0]), W'(10'h010));
        chk("m_last_addr", W'(addr_log[7]), W'(10'h017));
        chk("m_row5_col3", W'(data_log[5][C3*PSB +: PSB]), W'(83));
        chk("m_done_cyc", W'(m_done_cyc), W'(s + NR + MS + 1));

        // Gapped rows plus a stray row during drain.
        run_tile(10'h020, 3, 0, 1'b1);
        chk("err_drain", W'(bus.err), W'(1));

        // Address wrap at the top of the SRAM.
        run_tile(10'h3FE, 1, 1, 1'b0);
        chk("m_wrap_addr2", W'(addr_log[addr_log.size() - 6]), W'(10'h000));

        // Rows while idle: dropped, sticky err until the next start.
        drive(1'b0, 1'b0, '0, 1'b1, mkrow(1, 1));
        idle(2);
        drive(1'b0, 1'b0, '0, 1'b1, mkrow(2, 1));
        idle(2);
        chk("err_idle", W'(bus.err), W'(1));
        run_tile(10'h040, 2, 1, 1'b0);
        chk("err_cleared", W'(bus.err), W'(0));

        // Reset mid-tile after 3 accepted rows.
        drive(1'b0, 1'b1, 10'h080, 1'b0, '0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, '0, 1'b1, mkrow(k, 1));
        idle(2);
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        idle(MS + 2);
        chk("rst_busy", W'(bus.busy), W'(0));
        chk("rst_wr_en", W'(bus.wr_en), W'(0));
        run_tile(10'h100, 2, 1, 1'b0);

        // Negative values pass through bit-exact.
        run_tile(10'h200, 1, 2, 1'b0);
        chk("m_neg_col0", W'(data_log[data_log.size() - 8][C0*PSB +: PSB]), W'(20'hFFFFF));

        // Random tiles.
        for (int i = 0; i < 4; i++) run_tile(AS'($urandom), $urandom_range(0, 3), 1, 1'($urandom));
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
